// File: rtl/servo_motors.sv
// rtl/servo_motors.sv - single-channel RC-servo PWM generator with frame-aligned width updates
module servo_motors #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int PERIOD    = 1_000_000,
   parameter int PULSE_MIN = 50_000,
   parameter int PULSE_MAX = 100_000,
   parameter int CNT_W     = 20
) (
   input  logic mclk,
   input  logic reset,
   input  logic control_input,
   input  logic main_program,
   output logic servo
);

   // Constants narrowed once to counter width so every compare is CNT_W-bit unsigned.
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] WIDTH_MIN = CNT_W'(PULSE_MIN);
   localparam logic [CNT_W-1:0] WIDTH_MAX = CNT_W'(PULSE_MAX);

   // Refuse to elaborate with a counter too narrow for the frame or a nonsensical clock.
   if (CLK_HZ <= 0 || (64'd1 << CNT_W) < 64'(PERIOD) || PULSE_MAX >= PERIOD) begin : g_param_check
      $error("servo_motors: inconsistent parameters");
   end

   logic             ctl_meta;
   logic             ctl_s;
   logic             en_meta;
   logic             en_s;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] width_active;
   logic [CNT_W-1:0] width_next;

   // Width selected by the synchronized command; only sampled at reload points.
   assign width_next = ctl_s ? WIDTH_MAX : WIDTH_MIN;

   // Two-flop synchronizers for the asynchronous command and enable inputs.
   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         ctl_meta <= 1'b0;
         ctl_s    <= 1'b0;
         en_meta  <= 1'b0;
         en_s     <= 1'b0;
      end else begin
         ctl_meta <= control_input;
         ctl_s    <= ctl_meta;
         en_meta  <= main_program;
         en_s     <= en_meta;
      end
   end

   // Frame counter, latched width and registered output; width changes only at frame ends.
   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         counter      <= '0;
         width_active <= WIDTH_MIN;
         servo        <= 1'b0;
      end else if (!en_s) begin
         counter      <= '0;
         width_active <= width_next;
         servo        <= 1'b0;
      end else begin
         servo <= (counter < width_active);
         if (counter == LAST_CNT) begin
            counter      <= '0;
            width_active <= width_next;
         end else begin
            counter <= counter + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_servo_motors.sv
// tb/tb_servo_motors.sv - directed self-checking bench for servo_motors with a shortened frame
module tb_servo_motors;

   localparam int P    = 40;
   localparam int WMIN = 4;
   localparam int WMAX = 9;

   logic mclk = 1'b0;
   logic reset = 1'b0;
   logic control_input = 1'b0;
   logic main_program = 1'b0;
   logic servo;

   int n_cmp = 0;
   int n_bad = 0;

   servo_motors #(
      .PERIOD    (P),
      .PULSE_MIN (WMIN),
      .PULSE_MAX (WMAX),
      .CNT_W     (6)
   ) dut (
      .mclk          (mclk),
      .reset         (reset),
      .control_input (control_input),
      .main_program  (main_program),
      .servo         (servo)
   );

   always #5 mclk = ~mclk;

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Starts on the sample where servo has just gone high; ends on the next rise.
   task automatic measure(input int flip_at, input logic flip_val, input int exp_hi, input string tag);
      int hi;
      int lo;
      int i;
      hi = 0;
      lo = 0;
      i  = 0;
      chk({tag, "_rise_cnt"}, 32'(dut.counter), 32'd1);
      while (servo === 1'b1 && i < 2 * P) begin
         if (i == flip_at) control_input = flip_val;
         hi++;
         i++;
         step();
      end
      while (servo === 1'b0 && i < 2 * P) begin
         if (i == flip_at) control_input = flip_val;
         lo++;
         i++;
         step();
      end
      chk({tag, "_hi"}, 32'(hi), 32'(exp_hi));
      chk({tag, "_lo"}, 32'(lo), 32'(P - exp_hi));
   endtask

   initial begin
      // reset held while enable toggles
      for (int k = 0; k < 6; k++) begin
         main_program = ~main_program;
         step();
         chk("rst_servo", 32'(servo), 32'd0);
         chk("rst_cnt", 32'(dut.counter), 32'd0);
      end
      chk("rst_width", 32'(dut.width_active), 32'(WMIN));

      // release reset with enable low: stays idle
      main_program = 1'b0;
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("idle_servo", 32'(servo), 32'd0);
      end

      // enable: two sync clocks, then servo high on the third edge
      main_program = 1'b1;
      step();
      chk("lat1_servo", 32'(servo), 32'd0);
      step();
      chk("lat2_servo", 32'(servo), 32'd0);
      step();
      chk("lat3_servo", 32'(servo), 32'd1);

      // minimum pulse over three frames
      measure(-1, 1'b0, WMIN, "min_f1");
      measure(-1, 1'b0, WMIN, "min_f2");
      measure(-1, 1'b0, WMIN, "min_f3");

      // command change inside the pulse: current frame unchanged, next frame wide
      measure(1, 1'b1, WMIN, "sw_cur");
      measure(-1, 1'b1, WMAX, "sw_next");

      // change one clock before the last count: misses this boundary
      measure(P - 3, 1'b0, WMAX, "late_cur");
      measure(-1, 1'b0, WMAX, "late_next");
      measure(-1, 1'b0, WMIN, "late_after");

      // change five clocks before the last count: makes this boundary
      measure(P - 7, 1'b1, WMIN, "early_cur");
      measure(-1, 1'b1, WMAX, "early_next");

      // disable mid-pulse
      for (int k = 0; k < 4; k++) step();
      chk("dis_pre_servo", 32'(servo), 32'd1);
      chk("dis_pre_cnt", 32'(dut.counter), 32'd5);
      main_program = 1'b0;
      step();
      chk("dis1_servo", 32'(servo), 32'd1);
      step();
      chk("dis2_servo", 32'(servo), 32'd1);
      step();
      chk("dis3_servo", 32'(servo), 32'd0);
      chk("dis3_cnt", 32'(dut.counter), 32'd0);
      step();
      chk("dis4_cnt", 32'(dut.counter), 32'd0);

      // re-enable: fresh full frame
      main_program = 1'b1;
      step();
      step();
      step();
      chk("reen_servo", 32'(servo), 32'd1);
      measure(-1, 1'b1, WMAX, "reen_f1");

      // asynchronous reset between edges while the pulse is high
      step();
      step();
      chk("ar_pre_servo", 32'(servo), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_servo", 32'(servo), 32'd0);
      chk("ar_cnt", 32'(dut.counter), 32'd0);
      chk("ar_width", 32'(dut.width_active), 32'(WMIN));
      step();
      chk("ar_hold_servo", 32'(servo), 32'd0);
      reset = 1'b1;
      step();
      step();
      chk("ar_rel2_servo", 32'(servo), 32'd0);
      step();
      chk("ar_rel3_servo", 32'(servo), 32'd1);
      // idle reload saw the reset value of the synchronizer, so the first frame is narrow
      measure(-1, 1'b1, WMIN, "ar_f1");
      measure(-1, 1'b1, WMAX, "ar_f2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/servo_motors.md
# servo_motors

Single-channel RC-servo PWM generator driven from the 50 MHz system clock `mclk`. It produces a fixed 20 ms frame on `servo`, with a high pulse of 1 ms or 2 ms selected by the one-bit command `control_input`. Output only runs while the top-level enable `main_program` is asserted. It sits between the main control program and the servo pin.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency; documentation only, not used in arithmetic.
- `PERIOD`, 1_000_000: frame length in clocks (20 ms).
- `PULSE_MIN`, 50_000: high time in clocks when the command is 0 (1 ms).
- `PULSE_MAX`, 100_000: high time in clocks when the command is 1 (2 ms).
- `CNT_W`, 20: counter width; must satisfy 2^CNT_W ≥ PERIOD.
- `mclk`, in, 1: system clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset. `reset`=0 immediately clears all state.
- `control_input`, in, 1: pulse-width select (0 → PULSE_MIN, 1 → PULSE_MAX); asynchronous to `mclk`.
- `main_program`, in, 1: run enable, active-high; asynchronous to `mclk`.
- `servo`, out, 1: registered PWM output.

## Operation
- `control_input` and `main_program` each pass through a 2-flop synchronizer, giving `ctl_s` and `en_s`. Both synchronizer stages reset to 0.
- Internal registers:
  - `counter` (CNT_W bits, readable hierarchically as `counter`).
  - `width_active` (CNT_W bits).
  - `servo` register.
- Reset (`reset`=0, asynchronous):
  - `counter`=0.
  - `width_active`=PULSE_MIN.
  - `servo`=0.
  - synchronizers=0.
- Idle (`en_s`=0):
  - `counter` held at 0 and `servo`=0.
  - `width_active` reloads every clock from `ctl_s` (0 → PULSE_MIN, 1 → PULSE_MAX).
- Run (`en_s`=1), on each clock:
  - `servo` ← (`counter` < `width_active`).
  - `counter` ← (`counter` == PERIOD-1) ? 0 : `counter`+1.
  - When `counter` == PERIOD-1, `width_active` reloads from `ctl_s`; otherwise it is held.
- A command change therefore takes effect only at a frame boundary. No partial or glitched pulses are allowed.
- Comparison is unsigned. `counter` never exceeds PERIOD-1, so there is no wrap beyond PERIOD.
- Disable mid-frame (`en_s` falls): next clock `counter`=0 and `servo`=0. The frame is abandoned, not completed.
- Re-enable always starts a fresh frame from `counter`=0.

## Timing
- Input-to-effect latency: 2 clocks for synchronization.
- `servo` lags `counter` by one clock, since it is registered from the pre-increment value.
- After `en_s` rises, `servo` is high starting at the first edge, for exactly `width_active` consecutive clocks, then low for PERIOD−`width_active` clocks. The pattern repeats every PERIOD clocks.
- Exact values:
  - 1 ms pulse = 50,000 clocks high, 950,000 low.
  - 2 ms pulse = 100,000 high, 900,000 low.
- A `control_input` change within a frame affects the first frame that starts after the change has synchronized.
- Reset asserted at any time forces `servo`=0 asynchronously, without waiting for a clock edge.

## Test plan
- Reset hold: `reset`=0 with `main_program`=1 toggling → `servo`=0 and `counter`=0 throughout. Release `reset`=1 → no output until `en_s` is 1.
- Minimum pulse: `reset`=1, `main_program`=1, `control_input`=0 → `servo` high for exactly 50,000 clocks, low for 950,000, over 3 frames.
- Command switch mid-frame: set `control_input`=1 at 100 µs into a frame → current frame keeps its 50,000-clock pulse; the next frame's pulse is exactly 100,000 clocks, at 1,000,000-clock period.
- Change at boundary: toggle `control_input` 1 clock and 5 clocks before `counter`=PERIOD-1 → the new width applies to the next frame only if the change synchronized by the boundary; never a partial width.
- Disable mid-pulse: `main_program`→0 at `counter`=30,000 → `servo` low and `counter`=0 within 3 clocks. Re-enable → a full pulse from `counter`=0.
- Async reset mid-pulse: drive `reset`=0 between clock edges while `servo`=1 → `servo` drops immediately; after release, frame restarts with `width_active`=PULSE_MIN reloaded from `ctl_s` while idle.
